// File: rtl/shift_sched_pkg.sv
// Shared types and helpers for the round-robin serial scheduler.
//   sched_state_t : controller state encoding
//   rr_pick()     : round-robin grant index, scanning upward from last+1 with wrap
package shift_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } sched_state_t;

  // Upper bound on requesters the helper can scan; callers zero-extend to this width.
  localparam int unsigned MaxReq = 32;

  // Returns the first set bit of valid[nreq-1:0] starting at (last+1) mod nreq.
  // Returns 0 when nothing is valid; callers qualify with |valid.
  function automatic int unsigned rr_pick(input logic [MaxReq-1:0] valid,
                                          input int unsigned       last,
                                          input int unsigned       nreq);
    int unsigned idx;
    logic        found;
    rr_pick = 0;
    found   = 1'b0;
    for (int unsigned k = 1; k <= MaxReq; k++) begin
      if (k <= nreq) begin
        idx = last + k;
        // last < nreq and k <= nreq, so a single subtraction is enough to wrap.
        if (idx >= nreq) idx = idx - nreq;
        if (!found && valid[idx[4:0]]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/shift_dp.sv
// Parallel-load shift register datapath.
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous active-low reset, clears the register
//   load_i     : load data_i (has priority over shift_en_i)
//   data_i     : parallel word to load
//   shift_en_i : shift by one position, filling with 0
//   dir_i      : 1 = shift left / emit MSB, 0 = shift right / emit LSB
//   ser_o      : bit currently at the output end of the register
module shift_dp #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             shift_en_i,
  input  logic             dir_i,
  output logic             ser_o
);

  logic [Width-1:0] sreg_q, sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (load_i) begin
      sreg_d = data_i;
    end else if (shift_en_i) begin
      if (dir_i) sreg_d = {sreg_q[Width-2:0], 1'b0};
      else       sreg_d = {1'b0, sreg_q[Width-1:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sreg_q <= '0;
    else         sreg_q <= sreg_d;
  end

  assign ser_o = dir_i ? sreg_q[Width-1] : sreg_q[0];

endmodule

// File: rtl/shift_ser_sched.sv
// Round-robin scheduler sharing one parallel-load shift register among NREQ requesters.
// One word is accepted per frame, then emitted serially under downstream backpressure,
// optionally followed by forced idle gap cycles.
//   clk, rst_n         : clock (rising edge), asynchronous active-low reset
//   req_valid/req_data : per-requester word valid and packed words ([i*WIDTH +: WIDTH])
//   req_ready          : one-hot accept, only in IDLE; transfer = valid & ready
//   flush              : synchronous abort of the current frame
//   ser_valid/ready    : serial bit handshake
//   ser_data/ser_last  : current bit, and final-bit marker
//   ser_id             : requester owning the current frame
//   busy               : frame in progress (state != IDLE)
module shift_ser_sched
  import shift_sched_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned NREQ       = 4,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned MSB_FIRST  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     flush,
  output logic                     ser_valid,
  input  logic                     ser_ready,
  output logic                     ser_data,
  output logic                     ser_last,
  output logic [$clog2(NREQ)-1:0]  ser_id,
  output logic                     busy
);

  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam bit          HasGap = (GAP_CYCLES > 0);

  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IdW-1:0]  IdLast  = IdW'(NREQ - 1);

  sched_state_t    state_q, state_d;
  logic [IdW-1:0]  last_grant_q, last_grant_d;
  logic [IdW-1:0]  ser_id_q, ser_id_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;

  logic [IdW-1:0]   grant_idx;
  logic             grant_any;
  logic             load;
  logic             shift_en;
  logic             sreg_bit;
  logic             bit_last;
  logic [WIDTH-1:0] load_word;

  // Arbitration
  assign grant_idx = IdW'(rr_pick(32'(req_valid), 32'(last_grant_q), NREQ));
  assign grant_any = (state_q == ST_IDLE) && (|req_valid) && !flush;
  assign load_word = req_data[grant_idx*WIDTH +: WIDTH];

  // Gated by rst_n so nothing looks accepted while the block is held in reset.
  assign req_ready = (grant_any && rst_n) ? (NREQ'(1) << grant_idx) : '0;

  // Datapath
  shift_dp #(
    .Width (WIDTH)
  ) u_dp (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (load),
    .data_i     (load_word),
    .shift_en_i (shift_en),
    .dir_i      (MSB_FIRST != 0),
    .ser_o      (sreg_bit)
  );

  // Controller
  assign bit_last = (bit_cnt_q == CntLast);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ser_id_d     = ser_id_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    load         = 1'b0;
    shift_en     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          load         = 1'b1;
          ser_id_d     = grant_idx;
          last_grant_d = grant_idx;
          bit_cnt_d    = '0;
          state_d      = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ser_ready) begin
          shift_en = 1'b1;
          if (bit_last) begin
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            state_d   = HasGap ? ST_GAP : ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GapLast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything, including the last-bit handshake; last_grant is kept.
    if (flush && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IdLast;
      ser_id_q     <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ser_id_q     <= ser_id_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  // Outputs
  assign ser_valid = (state_q == ST_SHIFT);
  assign ser_data  = ser_valid & sreg_bit;
  assign ser_last  = ser_valid & bit_last;
  assign ser_id    = ser_id_q;
  assign busy      = (state_q != ST_IDLE);

  // req_ready must never name more than one requester.
  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

endmodule

// File: tb/tb_shift_ser_sched.sv
// Directed self-checking bench for shift_ser_sched.
// u_dut: default build (WIDTH=8, NREQ=4, GAP_CYCLES=1, MSB_FIRST=1).
// u_dut_b: GAP_CYCLES=0, MSB_FIRST=0 build for back-to-back LSB-first frames.
module tb_shift_ser_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        flush;
  logic        ser_valid;
  logic        ser_ready;
  logic        ser_data;
  logic        ser_last;
  logic [1:0]  ser_id;
  logic        busy;

  logic [3:0]  b_req_valid;
  logic [31:0] b_req_data;
  logic [3:0]  b_req_ready;
  logic        b_flush;
  logic        b_ser_valid;
  logic        b_ser_ready;
  logic        b_ser_data;
  logic        b_ser_last;
  logic [1:0]  b_ser_id;
  logic        b_busy;

  int n_checks = 0;
  int n_errors = 0;

  shift_ser_sched #(
    .WIDTH      (8),
    .NREQ       (4),
    .GAP_CYCLES (1),
    .MSB_FIRST  (1)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .flush     (flush),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_data  (ser_data),
    .ser_last  (ser_last),
    .ser_id    (ser_id),
    .busy      (busy)
  );

  shift_ser_sched #(
    .WIDTH      (8),
    .NREQ       (4),
    .GAP_CYCLES (0),
    .MSB_FIRST  (0)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (b_req_valid),
    .req_data  (b_req_data),
    .req_ready (b_req_ready),
    .flush     (b_flush),
    .ser_valid (b_ser_valid),
    .ser_ready (b_ser_ready),
    .ser_data  (b_ser_data),
    .ser_last  (b_ser_last),
    .ser_id    (b_ser_id),
    .busy      (b_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid   = '0;
    req_data    = '0;
    flush       = 1'b0;
    ser_ready   = 1'b1;
    b_req_valid = '0;
    b_req_data  = '0;
    b_flush     = 1'b0;
    b_ser_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #7;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] pat;
    int         acc_cyc [5];
    int         acc_id  [5];
    int         nacc;

    // Reset state, with requests pending to show req_ready is gated.
    idle_inputs();
    rst_n = 1'b0;
    #3;
    req_valid = 4'hF;
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_ser_valid", 32'(ser_valid), 0);
    check("rst_ser_data", 32'(ser_data), 0);
    check("rst_ser_last", 32'(ser_last), 0);
    check("rst_ser_id", 32'(ser_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_b_busy", 32'(b_busy), 0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1. Single frame of A5 from requester 0, MSB first, then one gap cycle.
    pat       = 8'hA5;
    req_valid = 4'b0001;
    req_data  = 32'h0000_00A5;
    #1;
    check("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    check("t1_ser_id", 32'(ser_id), 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_valid%0d", i), 32'(ser_valid), 1);
      check($sformatf("t1_bit%0d", i), 32'(ser_data), 32'(pat[7-i]));
      check($sformatf("t1_last%0d", i), 32'(ser_last), 32'(i == 7));
      tick();
    end
    check("t1_gap_valid", 32'(ser_valid), 0);
    check("t1_gap_busy", 32'(busy), 1);
    req_valid = 4'b0001;
    #1;
    check("t1_gap_ready", 32'(req_ready), 0);
    tick();
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_idle_ready", 32'(req_ready), 32'h1);
    req_valid = '0;

    // 2. Round-robin with all four valid: grants 0,1,2,3,0, ten cycles apart.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      acc_cyc[k] = -1;
      acc_id[k]  = -1;
    end
    nacc      = 0;
    req_valid = 4'hF;
    req_data  = 32'h4433_2211;
    #1;
    for (int c = 0; c < 60; c++) begin
      if (req_ready != 0) begin
        acc_cyc[nacc] = c;
        for (int j = 0; j < 4; j++) if (req_ready[j]) acc_id[nacc] = j;
        nacc++;
      end
      if (nacc == 5) break;
      tick();
    end
    check("t2_naccept", 32'(nacc), 5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t2_grant%0d", k), 32'(acc_id[k]), 32'(k % 4));
      if (k > 0) check($sformatf("t2_spacing%0d", k), 32'(acc_cyc[k] - acc_cyc[k-1]), 10);
    end
    req_valid = '0;

    // 3. Backpressure for 3 cycles at bit 4 of 3C.
    do_reset();
    pat       = 8'h3C;
    req_valid = 4'b0001;
    req_data  = 32'h0000_003C;
    tick();
    req_valid = '0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_bit%0d", i), 32'(ser_data), 32'(pat[7-i]));
      check($sformatf("t3_last%0d", i), 32'(ser_last), 32'(i == 7));
      if (i == 4) begin
        ser_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          check($sformatf("t3_hold_valid%0d", s), 32'(ser_valid), 1);
          check($sformatf("t3_hold_bit%0d", s), 32'(ser_data), 32'(pat[3]));
          check($sformatf("t3_hold_last%0d", s), 32'(ser_last), 0);
        end
        ser_ready = 1'b1;
      end
      tick();
    end
    check("t3_gap_valid", 32'(ser_valid), 0);

    // 4. Flush at bit 2 of a frame from requester 2; next grant goes to 3.
    do_reset();
    req_valid = 4'b0100;
    req_data  = 32'hC300_5A00;
    #1;
    check("t4_ready2", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    check("t4_ser_id", 32'(ser_id), 2);
    tick();
    tick();
    flush = 1'b1;
    tick();
    check("t4_flush_valid", 32'(ser_valid), 0);
    check("t4_flush_last", 32'(ser_last), 0);
    check("t4_flush_busy", 32'(busy), 0);
    req_valid = 4'hF;
    #1;
    check("t4_flush_idle_ready", 32'(req_ready), 0);
    flush = 1'b0;
    #1;
    check("t4_next_ready3", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    check("t4_ser_id3", 32'(ser_id), 3);
    repeat (7) tick();
    check("t4_at_last", 32'(ser_last), 1);
    // Flush together with the last-bit handshake: straight to IDLE, no gap.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_flushlast_busy", 32'(busy), 0);
    check("t4_flushlast_valid", 32'(ser_valid), 0);
    req_valid = 4'hF;
    #1;
    check("t4_wrap_ready0", 32'(req_ready), 32'h1);
    req_valid = '0;

    // 5. Asynchronous reset at bit 5 of a frame from requester 1.
    do_reset();
    req_valid = 4'b0010;
    req_data  = 32'h0000_A500;
    #1;
    check("t5_ready1", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'hF;
    repeat (5) tick();
    check("t5_pre_id", 32'(ser_id), 1);
    check("t5_pre_valid", 32'(ser_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(ser_valid), 0);
    check("t5_rst_data", 32'(ser_data), 0);
    check("t5_rst_last", 32'(ser_last), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_id", 32'(ser_id), 0);
    check("t5_rst_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t5_post_ready0", 32'(req_ready), 32'h1);
    tick();
    check("t5_post_id", 32'(ser_id), 0);
    check("t5_post_valid", 32'(ser_valid), 1);
    req_valid = '0;

    // 6. GAP_CYCLES=0, LSB-first build: two back-to-back frames of 01.
    do_reset();
    b_req_valid = 4'b0001;
    b_req_data  = 32'h0000_0001;
    #1;
    check("t6_ready", 32'(b_req_ready), 32'h1);
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t6_bit%0d", i), 32'(b_ser_data), 32'(i == 0));
      check($sformatf("t6_last%0d", i), 32'(b_ser_last), 32'(i == 7));
      tick();
    end
    check("t6_between_valid", 32'(b_ser_valid), 0);
    check("t6_between_busy", 32'(b_busy), 0);
    check("t6_reaccept", 32'(b_req_ready), 32'h1);
    tick();
    check("t6_second_valid", 32'(b_ser_valid), 1);
    check("t6_second_bit0", 32'(b_ser_data), 1);
    b_req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
